// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard controller for a five-stage pipeline.
// Tracks EX/MEM destination tags and produces operand selects, store-data forward and stall.
module fwd_hazard_unit #(
    parameter int REG_W   = 5,
    parameter int NUM_SRC = 2,
    parameter int ST_SRC  = 1,
    parameter int CNT_W   = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       id_valid,
    input  logic [NUM_SRC*REG_W-1:0]   id_src,
    input  logic [NUM_SRC-1:0]         id_src_used,
    input  logic [REG_W-1:0]           id_dst,
    input  logic                       id_wen,
    input  logic                       id_load,
    input  logic                       id_store,
    input  logic                       flush,
    output logic                       stall,
    output logic [2*NUM_SRC-1:0]       fwd_ex,
    output logic                       fwd_mem_st,
    output logic [CNT_W-1:0]           stall_cnt
);

    // The WB record is not kept: the register file is write-first, so a WB
    // producer is already visible to ID and never needs a forward select.
    logic             ex_valid;
    logic [REG_W-1:0] ex_dst;
    logic             ex_wen;
    logic             ex_load;
    logic             ex_pend;

    logic             mem_valid;
    logic [REG_W-1:0] mem_dst;
    logic             mem_wen;

    logic                 ex_live;
    logic                 mem_live;
    logic [NUM_SRC-1:0]   match_ex;
    logic [NUM_SRC-1:0]   match_mem;
    logic [NUM_SRC-1:0]   ld_hit;
    logic [NUM_SRC-1:0]   st_mask;
    logic                 other_ld;
    logic                 load_use;
    logic                 st_pend_id;
    logic [2*NUM_SRC-1:0] fwd_next;
    logic [REG_W-1:0]     src;

    assign ex_live  = ex_valid && ex_wen && (ex_dst != '0);
    assign mem_live = mem_valid && mem_wen && (mem_dst != '0);

    always_comb begin
        match_ex   = '0;
        match_mem  = '0;
        fwd_next   = '0;
        st_mask    = '0;
        src        = '0;
        st_mask[ST_SRC] = 1'b1;
        for (int i = 0; i < NUM_SRC; i++) begin
            src          = id_src[i*REG_W +: REG_W];
            match_ex[i]  = id_valid && id_src_used[i] && ex_live && (src == ex_dst);
            match_mem[i] = id_valid && id_src_used[i] && mem_live && (src == mem_dst);
            if (match_ex[i] && !ex_load)
                fwd_next[2*i +: 2] = 2'b01;
            else if (match_mem[i])
                fwd_next[2*i +: 2] = 2'b10;
            else
                fwd_next[2*i +: 2] = 2'b00;
        end
        ld_hit = match_ex & {NUM_SRC{ex_load}};
        // A store whose only load dependency is its data operand picks the
        // value up in MEM instead of stalling.
        other_ld   = |(ld_hit & ~st_mask);
        load_use   = other_ld || (ld_hit[ST_SRC] && !id_store);
        st_pend_id = ld_hit[ST_SRC] && id_store && !other_ld;
    end

    assign stall = load_use && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid   <= 1'b0;
            ex_dst     <= '0;
            ex_wen     <= 1'b0;
            ex_load    <= 1'b0;
            ex_pend    <= 1'b0;
            mem_valid  <= 1'b0;
            mem_dst    <= '0;
            mem_wen    <= 1'b0;
            fwd_ex     <= '0;
            fwd_mem_st <= 1'b0;
        end else if (flush) begin
            ex_valid   <= 1'b0;
            ex_dst     <= '0;
            ex_wen     <= 1'b0;
            ex_load    <= 1'b0;
            ex_pend    <= 1'b0;
            mem_valid  <= 1'b0;
            mem_dst    <= '0;
            mem_wen    <= 1'b0;
            fwd_ex     <= '0;
            fwd_mem_st <= 1'b0;
        end else begin
            mem_valid  <= ex_valid;
            mem_dst    <= ex_dst;
            mem_wen    <= ex_wen;
            fwd_mem_st <= ex_valid && ex_pend;
            if (stall) begin
                ex_valid <= 1'b0;
                ex_dst   <= '0;
                ex_wen   <= 1'b0;
                ex_load  <= 1'b0;
                ex_pend  <= 1'b0;
                fwd_ex   <= '0;
            end else begin
                ex_valid <= id_valid;
                ex_dst   <= id_dst;
                ex_wen   <= id_wen;
                ex_load  <= id_load;
                ex_pend  <= st_pend_id;
                fwd_ex   <= fwd_next;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt <= '0;
        else if (stall && (stall_cnt != '1))
            stall_cnt <= stall_cnt + CNT_W'(1);
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit; a second instance with a 2-bit counter
// shares the stimulus to exercise counter saturation.
module tb_fwd_hazard_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [9:0]  id_src;
    logic [1:0]  id_src_used;
    logic [4:0]  id_dst;
    logic        id_wen;
    logic        id_load;
    logic        id_store;
    logic        flush;

    logic        stall;
    logic [3:0]  fwd_ex;
    logic        fwd_mem_st;
    logic [15:0] stall_cnt;

    logic        stall_s;
    logic [3:0]  fwd_ex_s;
    logic        fwd_mem_st_s;
    logic [1:0]  stall_cnt_s;

    int total = 0;
    int bad = 0;
    int exp_cnt = 0;
    int exp_sat = 0;

    always #5 clk = ~clk;

    fwd_hazard_unit u_dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_src(id_src),
        .id_src_used(id_src_used), .id_dst(id_dst), .id_wen(id_wen),
        .id_load(id_load), .id_store(id_store), .flush(flush),
        .stall(stall), .fwd_ex(fwd_ex), .fwd_mem_st(fwd_mem_st), .stall_cnt(stall_cnt)
    );

    fwd_hazard_unit #(.CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_src(id_src),
        .id_src_used(id_src_used), .id_dst(id_dst), .id_wen(id_wen),
        .id_load(id_load), .id_store(id_store), .flush(flush),
        .stall(stall_s), .fwd_ex(fwd_ex_s), .fwd_mem_st(fwd_mem_st_s), .stall_cnt(stall_cnt_s)
    );

    task automatic drive(input logic v, input logic [4:0] s0, input logic [4:0] s1,
                         input logic [1:0] used, input logic [4:0] dst, input logic wen,
                         input logic ld, input logic st);
        id_valid    = v;
        id_src      = {s1, s0};
        id_src_used = used;
        id_dst      = dst;
        id_wen      = wen;
        id_load     = ld;
        id_store    = st;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic nops(input int n);
        drive(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < n; k++) tick();
    endtask

    // Book-keeping for one expected stall edge on both counters.
    task automatic count_stall();
        exp_cnt++;
        if (exp_sat < 3) exp_sat++;
    endtask

    task automatic test_reset_initial();
        rst_n = 1'b0;
        flush = 1'b0;
        drive(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0);
        #12;
        total++; if (stall !== 1'b0) begin bad++; $display("[TB] FAIL init_stall got %b want 0", stall); end
        total++; if (fwd_ex !== 4'b0000) begin bad++; $display("[TB] FAIL init_fwd_ex got %b want 0000", fwd_ex); end
        total++; if (fwd_mem_st !== 1'b0) begin bad++; $display("[TB] FAIL init_fwd_mem_st got %b want 0", fwd_mem_st); end
        total++; if (stall_cnt !== 16'd0) begin bad++; $display("[TB] FAIL init_cnt got %0d want 0", stall_cnt); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_alu_back_to_back();
        drive(1'b1, 5'd1, 5'd2, 2'b11, 5'd3, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 5'd3, 5'd3, 2'b11, 5'd4, 1'b1, 1'b0, 1'b0);
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("[TB] FAIL alu_no_stall got %b want 0", stall); end
        tick();
        total++; if (fwd_ex !== 4'b0101) begin bad++; $display("[TB] FAIL alu_ex_fwd got %b want 0101", fwd_ex); end
        drive(1'b1, 5'd3, 5'd0, 2'b11, 5'd5, 1'b1, 1'b0, 1'b0);
        tick();
        total++; if (fwd_ex !== 4'b0010) begin bad++; $display("[TB] FAIL alu_mem_fwd got %b want 0010", fwd_ex); end
        drive(1'b1, 5'd3, 5'd9, 2'b11, 5'd6, 1'b1, 1'b0, 1'b0);
        tick();
        total++; if (fwd_ex !== 4'b0000) begin bad++; $display("[TB] FAIL alu_rf got %b want 0000", fwd_ex); end
        nops(3);
    endtask

    task automatic test_load_use();
        drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd5, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd5, 5'd1, 2'b11, 5'd6, 1'b1, 1'b0, 1'b0);
        #1;
        total++; if (stall !== 1'b1) begin bad++; $display("[TB] FAIL lu_stall got %b want 1", stall); end
        tick();
        count_stall();
        total++; if (stall !== 1'b0) begin bad++; $display("[TB] FAIL lu_release got %b want 0", stall); end
        total++; if (stall_cnt !== 16'(exp_cnt)) begin bad++; $display("[TB] FAIL lu_cnt got %0d want %0d", stall_cnt, exp_cnt); end
        tick();
        total++; if (fwd_ex !== 4'b0010) begin bad++; $display("[TB] FAIL lu_fwd got %b want 0010", fwd_ex); end
        nops(3);
    endtask

    task automatic test_load_store();
        drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd7, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd2, 5'd7, 2'b11, 5'd0, 1'b0, 1'b0, 1'b1);
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("[TB] FAIL ls_no_stall got %b want 0", stall); end
        tick();
        total++; if (fwd_mem_st !== 1'b0) begin bad++; $display("[TB] FAIL ls_before got %b want 0", fwd_mem_st); end
        total++; if (fwd_ex !== 4'b0000) begin bad++; $display("[TB] FAIL ls_ex_sel got %b want 0000", fwd_ex); end
        nops(1);
        total++; if (fwd_mem_st !== 1'b1) begin bad++; $display("[TB] FAIL ls_mem_st got %b want 1", fwd_mem_st); end
        tick();
        total++; if (fwd_mem_st !== 1'b0) begin bad++; $display("[TB] FAIL ls_after got %b want 0", fwd_mem_st); end
        nops(2);
        // Store whose address operand also hits the load must still stall.
        drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd8, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd8, 5'd8, 2'b11, 5'd0, 1'b0, 1'b0, 1'b1);
        #1;
        total++; if (stall !== 1'b1) begin bad++; $display("[TB] FAIL st_other_stall got %b want 1", stall); end
        tick();
        count_stall();
        tick();
        total++; if (fwd_ex !== 4'b1010) begin bad++; $display("[TB] FAIL st_other_fwd got %b want 1010", fwd_ex); end
        nops(1);
        total++; if (fwd_mem_st !== 1'b0) begin bad++; $display("[TB] FAIL st_other_pend got %b want 0", fwd_mem_st); end
        nops(3);
    endtask

    task automatic test_reg_zero_unused();
        drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd0, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd0, 5'd0, 2'b11, 5'd1, 1'b1, 1'b0, 1'b0);
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("[TB] FAIL r0_no_stall got %b want 0", stall); end
        tick();
        total++; if (fwd_ex !== 4'b0000) begin bad++; $display("[TB] FAIL r0_sel got %b want 0000", fwd_ex); end
        nops(3);
        drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd9, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd9, 5'd1, 2'b10, 5'd2, 1'b1, 1'b0, 1'b0);
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("[TB] FAIL unused_no_stall got %b want 0", stall); end
        tick();
        total++; if (fwd_ex !== 4'b0000) begin bad++; $display("[TB] FAIL unused_sel got %b want 0000", fwd_ex); end
        nops(3);
    endtask

    task automatic test_flush();
        drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd10, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd10, 5'd1, 2'b11, 5'd2, 1'b1, 1'b0, 1'b0);
        flush = 1'b1;
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("[TB] FAIL flush_stall got %b want 0", stall); end
        tick();
        flush = 1'b0;
        total++; if (stall_cnt !== 16'(exp_cnt)) begin bad++; $display("[TB] FAIL flush_cnt got %0d want %0d", stall_cnt, exp_cnt); end
        drive(1'b1, 5'd10, 5'd1, 2'b11, 5'd3, 1'b1, 1'b0, 1'b0);
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("[TB] FAIL flush_ex_bubble got %b want 0", stall); end
        tick();
        total++; if (fwd_ex !== 4'b0000) begin bad++; $display("[TB] FAIL flush_mem_bubble got %b want 0000", fwd_ex); end
        total++; if (fwd_mem_st !== 1'b0) begin bad++; $display("[TB] FAIL flush_mem_st got %b want 0", fwd_mem_st); end
        nops(3);
    endtask

    task automatic test_saturation();
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd11, 1'b1, 1'b1, 1'b0);
            tick();
            drive(1'b1, 5'd11, 5'd1, 2'b01, 5'd12, 1'b1, 1'b0, 1'b0);
            #1;
            total++; if (stall !== 1'b1) begin bad++; $display("[TB] FAIL sat_stall[%0d] got %b want 1", k, stall); end
            tick();
            count_stall();
            nops(2);
        end
        total++; if (stall_cnt_s !== 2'(exp_sat)) begin bad++; $display("[TB] FAIL sat_cnt got %0d want %0d", stall_cnt_s, exp_sat); end
        total++; if (stall_cnt_s !== 2'd3) begin bad++; $display("[TB] FAIL sat_max got %0d want 3", stall_cnt_s); end
        total++; if (stall_cnt !== 16'(exp_cnt)) begin bad++; $display("[TB] FAIL main_cnt got %0d want %0d", stall_cnt, exp_cnt); end
    endtask

    task automatic test_reset_mid_stall();
        drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd12, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd12, 5'd1, 2'b11, 5'd13, 1'b1, 1'b0, 1'b0);
        #1;
        total++; if (stall !== 1'b1) begin bad++; $display("[TB] FAIL rst_pre_stall got %b want 1", stall); end
        rst_n = 1'b0;
        exp_cnt = 0;
        exp_sat = 0;
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("[TB] FAIL rst_stall got %b want 0", stall); end
        total++; if (fwd_ex !== 4'b0000) begin bad++; $display("[TB] FAIL rst_fwd_ex got %b want 0000", fwd_ex); end
        total++; if (fwd_mem_st !== 1'b0) begin bad++; $display("[TB] FAIL rst_fwd_mem_st got %b want 0", fwd_mem_st); end
        total++; if (stall_cnt !== 16'd0) begin bad++; $display("[TB] FAIL rst_cnt got %0d want 0", stall_cnt); end
        total++; if (stall_cnt_s !== 2'd0) begin bad++; $display("[TB] FAIL rst_sat_cnt got %0d want 0", stall_cnt_s); end
        #1;
        rst_n = 1'b1;
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("[TB] FAIL rst_empty got %b want 0", stall); end
        tick();
        total++; if (fwd_ex !== 4'b0000) begin bad++; $display("[TB] FAIL rst_first_sel got %b want 0000", fwd_ex); end
        total++; if (stall_cnt !== 16'd0) begin bad++; $display("[TB] FAIL rst_cnt_after got %0d want 0", stall_cnt); end
        nops(2);
    endtask

    initial begin
        test_reset_initial();
        test_alu_back_to_back();
        test_load_use();
        test_load_store();
        test_reg_zero_unused();
        test_flush();
        test_saturation();
        test_reset_mid_stall();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
